bl_refresh_sched: RTL and testbench
===================================

// Module: bl_refresh_sched
// PURPOSE
//  Sequences every refresh of the zonal-backlight LED driver write port and selects where brightness comes from.
//  - Holds off while the driver's registers are configured.
//  - Then, once per period: issues the SDBP strobe, streams all zone values as addr/data/we, and flags completion.
//  - Data source per frame: the video zone-gray RAM (1-cycle read) or one built-in pattern (all-on, chase, thirds, off).
//  - Sits between the zone statistics RAM and the LED driver SPI/SDBP engine, in the clk domain.
// PARAMETERS
//  ZCOLS       24      zone columns
//  ZROWS       15      zone rows; NZONES = ZCOLS*ZROWS = 360
//  CFG_CYCLES  2500    clk cycles held in CFG_WAIT after reset
//  PERIOD      35000   clk cycles between refresh ticks; must be >= PULSE_LEN+NZONES+8
//  PULSE_LEN   30      sdbp_o high time in cycles
//  CHASE_DIV   20      frames per chase step
//  ALS_K       3       ambient gain multiplier (ALS_GAIN_EN only)
// PORTS
//  clk          in   1   25 MHz system clock
//  rst_n        in   1   async active-low reset
//  mode_i       in   3   0 video, 1 all-on, 2 chase, 3 thirds, 4-7 off
//  zr_addr_o    out  9   zone RAM read address, row-major (row*ZCOLS+col)
//  zr_data_i    in   8   zone gray; valid 1 cycle after zr_addr_o
//  als_i        in   8   ambient light level (ALS_GAIN_EN only)
//  sdbp_o       out  1   SDBP strobe to driver
//  wt_we_o      out  1   write strobe, one per zone
//  wt_addr_o    out  10  driver RAM address 0..NZONES-1
//  wt_data_o    out  16  zone PWM value
//  busy_o       out  1   high in PULSE/STREAM/FLUSH
//  frame_done_o out  1   1-cycle pulse after the last write
// BEHAVIOUR
//  Reset: every output 0; FSM=CFG_WAIT; period counter 0; chase_pos 0; frame count 0. Reset mid-stream aborts immediately, with no partial-frame completion.
//  FSM:
//  - CFG_WAIT: count CFG_CYCLES, then go to IDLE and start the period counter.
//  - IDLE: on tick, go to PULSE.
//  - PULSE: sdbp_o=1 for exactly PULSE_LEN cycles, then go to STREAM.
//  - STREAM: idx 0..NZONES-1, one per cycle, drives zr_addr_o=idx.
//  - FLUSH: 1 cycle, emits the last write, then go to DONE.
//  - DONE: frame_done_o=1, then go to IDLE.
//  Period counter: counts 0..PERIOD-1 and wraps; tick = (count==PERIOD-1). A tick arriving outside IDLE is dropped, never queued.
//  Mode is latched on PULSE entry. mode_i changes mid-frame take effect on the next frame.
//  Write pipeline: wt_we_o/wt_addr_o/wt_data_o are registered 1 cycle after the idx that drives them.
//  - Exactly NZONES writes per frame, on consecutive cycles, addresses ascending from 0.
//  - Outside writes, wt_addr_o and wt_data_o are held at 0.
//  Column/row are tracked with wrap counters; no divide or modulo on idx.
//  Data by mode:
//  - video: {zr_data_i,8'h00}.
//  - all-on: 16'hFFFF.
//  - chase: 16'h0FFF when idx==chase_pos, else 0.
//  - thirds: col<ZCOLS/3 gives 16'hFFFF; col<2*ZCOLS/3 gives 16'h0100; otherwise 0.
//  - off: 0.
//  Chase: at DONE of each chase frame the frame counter increments. At CHASE_DIV it clears, and chase_pos steps, wrapping NZONES-1 to 0. The counter freezes in other modes.
// CONFIGURATION
//  `ALS_GAIN_EN defined:
//  - als_i port exists.
//  - Video data = min({zr,8'h00} + als_i*ALS_K, 16'hFFFF); the sum is 17 bits wide, saturating.
//  - als_i is sampled on PULSE entry.
//  Undefined: als_i and ALS_K logic are absent; video data is unmodified.
// STRUCTURE
//  Package bl_pkg:
//  - ZCOLS/ZROWS/NZONES constants.
//  - mode enum (MODE_VIDEO, MODE_ALLON, MODE_CHASE, MODE_THIRDS, MODE_OFF).
//  - FSM state typedef.
//  - PWM constants FULL=16'hFFFF, HALF=16'h0100, CHASE=16'h0FFF.
//  Sub-module bl_pattern_gen: given mode, col, idx and chase_pos, returns the 16-bit pattern value (combinational plus chase registers).
// TESTING
//  Reset release, mode=1 -> sdbp_o first rises after CFG_CYCLES + PERIOD cycles; then 360 writes, all FFFF, addr 0..359; one frame_done_o.
//  Video, zone RAM model with data=addr[7:0] -> wt_data_o at addr 300 is 16'h2C00; writes are consecutive, exactly 360 per frame.
//  Thirds -> addr 0..7 = FFFF, 8..15 = 0100, 16..23 = 0000; the pattern repeats per row through addr 359.
//  Chase, CHASE_DIV=2 -> frames 1-2 light only addr 0; frames 3-4 only addr 1. With NZONES=4 override, the step after addr 3 returns to 0.
//  mode_i toggled mid-STREAM; rst_n pulsed mid-STREAM -> the current frame is unchanged; reset zeroes all outputs and restarts CFG_WAIT.
//  ALS_GAIN_EN, zr=F0, als_i=FF -> 16'hF2FD; zr=FF, als_i=FF -> 16'hFFFF (saturated).

Source files
------------

// File: rtl/bl_pkg.sv
// ============================================================================
//  Module : bl_pkg
//  Zonal-backlight refresh scheduler shared types, constants and helpers.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bl_pkg;

  localparam int DEF_ZCOLS  = 24;
  localparam int DEF_ZROWS  = 15;
  localparam int DEF_NZONES = DEF_ZCOLS * DEF_ZROWS;

  localparam logic [15:0] FULL  = 16'hFFFF;
  localparam logic [15:0] HALF  = 16'h0100;
  localparam logic [15:0] CHASE = 16'h0FFF;

  typedef enum logic [2:0] {
    MODE_VIDEO  = 3'd0,
    MODE_ALLON  = 3'd1,
    MODE_CHASE  = 3'd2,
    MODE_THIRDS = 3'd3,
    MODE_OFF    = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    ST_CFG_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PULSE    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Codes 4..7 all collapse to the off pattern.
  function automatic mode_e decode_mode(input logic [2:0] m);
    mode_e r;
    case (m)
      3'd0:    r = MODE_VIDEO;
      3'd1:    r = MODE_ALLON;
      3'd2:    r = MODE_CHASE;
      3'd3:    r = MODE_THIRDS;
      default: r = MODE_OFF;
    endcase
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bl_pattern_gen.sv
// ============================================================================
//  Module : bl_pattern_gen
//  Built-in brightness patterns plus the chase position/frame registers.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bl_pattern_gen
  import bl_pkg::*;
#(
  parameter int ZCOLS     = DEF_ZCOLS,
  parameter int NZONES    = DEF_NZONES,
  parameter int CHASE_DIV = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  mode_e                   mode_i,
  input  logic [cnt_w(ZCOLS)-1:0] col_i,
  input  logic [8:0]              idx_i,
  input  logic                    frame_end_i,
  output logic [15:0]             pat_o
);

  localparam int              c_cw       = cnt_w(ZCOLS);
  localparam int              c_fw       = cnt_w(CHASE_DIV);
  localparam logic [c_cw-1:0] c_third1   = c_cw'(ZCOLS / 3);
  localparam logic [c_cw-1:0] c_third2   = c_cw'(2 * ZCOLS / 3);
  localparam logic [c_fw-1:0] c_div_last = c_fw'(CHASE_DIV - 1);
  localparam logic [8:0]      c_pos_last = 9'(NZONES - 1);

  logic [c_fw-1:0] r_frame_cnt;
  logic [8:0]      r_chase_pos;

  // Advances only on completed chase frames, so other modes freeze the chase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_chase_pos <= '0;
    end else if (frame_end_i) begin
      if (r_frame_cnt == c_div_last) begin
        r_frame_cnt <= '0;
        r_chase_pos <= (r_chase_pos == c_pos_last) ? 9'd0 : r_chase_pos + 9'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pat_o = '0;
    case (mode_i)
      MODE_ALLON:  pat_o = FULL;
      MODE_CHASE:  if (idx_i == r_chase_pos) pat_o = CHASE;
      MODE_THIRDS: begin
        if (col_i < c_third1)      pat_o = FULL;
        else if (col_i < c_third2) pat_o = HALF;
      end
      default:     pat_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bl_refresh_sched.sv
// ============================================================================
//  Module : bl_refresh_sched
//  Periodic LED-driver refresh sequencer; define ALS_GAIN_EN for ambient gain.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bl_refresh_sched
  import bl_pkg::*;
#(
  parameter int ZCOLS      = DEF_ZCOLS,
  parameter int ZROWS      = DEF_ZROWS,
  parameter int CFG_CYCLES = 2500,
  parameter int PERIOD     = 35000,
  parameter int PULSE_LEN  = 30,
  parameter int CHASE_DIV  = 20
`ifdef ALS_GAIN_EN
  , parameter int ALS_K    = 3
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mode_i,
  output logic [8:0]  zr_addr_o,
  input  logic [7:0]  zr_data_i,
`ifdef ALS_GAIN_EN
  input  logic [7:0]  als_i,
`endif
  output logic        sdbp_o,
  output logic        wt_we_o,
  output logic [9:0]  wt_addr_o,
  output logic [15:0] wt_data_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int               c_nzones   = ZCOLS * ZROWS;
  localparam int               c_cw       = cnt_w(ZCOLS);
  localparam int               c_cfgw     = cnt_w(CFG_CYCLES);
  localparam int               c_perw     = cnt_w(PERIOD);
  localparam int               c_plw      = cnt_w(PULSE_LEN);
  localparam logic [c_cfgw-1:0] c_cfg_last = c_cfgw'(CFG_CYCLES - 1);
  localparam logic [c_perw-1:0] c_per_last = c_perw'(PERIOD - 1);
  localparam logic [c_plw-1:0]  c_pl_last  = c_plw'(PULSE_LEN - 1);
  localparam logic [c_cw-1:0]   c_col_last = c_cw'(ZCOLS - 1);
  localparam logic [8:0]        c_idx_last = 9'(c_nzones - 1);

  state_e            r_state, w_next;
  logic [c_cfgw-1:0] r_cfg_cnt;
  logic [c_perw-1:0] r_per_cnt;
  logic [c_plw-1:0]  r_pcnt;
  logic [8:0]        r_idx;
  logic [c_cw-1:0]   r_col;
  mode_e             r_mode;
  logic              r_we;
  logic [9:0]        r_addr;
  logic [15:0]       r_pat;
  logic [15:0]       w_pat;
  logic [15:0]       w_video;
  logic              w_tick;

  assign w_tick = (r_state != ST_CFG_WAIT) && (r_per_cnt == c_per_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CFG_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CFG_WAIT: if (r_cfg_cnt == c_cfg_last) w_next = ST_IDLE;
      ST_IDLE:     if (w_tick) w_next = ST_PULSE;
      ST_PULSE:    if (r_pcnt == c_pl_last) w_next = ST_STREAM;
      ST_STREAM:   if (r_idx == c_idx_last) w_next = ST_FLUSH;
      ST_FLUSH:    w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_CFG_WAIT;
    endcase
  end

  always_comb begin
    sdbp_o       = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (r_state)
      ST_PULSE: begin
        sdbp_o = 1'b1;
        busy_o = 1'b1;
      end
      ST_STREAM, ST_FLUSH: busy_o = 1'b1;
      ST_DONE:  frame_done_o = 1'b1;
      default:  ;
    endcase
  end

  // The period counter free-runs once configuration ends; ticks outside IDLE are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_cnt <= '0;
      r_per_cnt <= '0;
      r_pcnt    <= '0;
      r_idx     <= '0;
      r_col     <= '0;
      r_mode    <= MODE_VIDEO;
    end else begin
      if (r_state == ST_CFG_WAIT) r_cfg_cnt <= r_cfg_cnt + 1'b1;
      if (r_state != ST_CFG_WAIT) r_per_cnt <= w_tick ? '0 : r_per_cnt + 1'b1;
      r_pcnt <= (r_state == ST_PULSE) ? r_pcnt + 1'b1 : '0;
      if (r_state == ST_STREAM && w_next == ST_STREAM) begin
        r_idx <= r_idx + 9'd1;
        r_col <= (r_col == c_col_last) ? '0 : r_col + 1'b1;
      end else begin
        r_idx <= '0;
        r_col <= '0;
      end
      if (r_state == ST_IDLE && w_tick) r_mode <= decode_mode(mode_i);
    end
  end

  bl_pattern_gen #(
    .ZCOLS     (ZCOLS),
    .NZONES    (c_nzones),
    .CHASE_DIV (CHASE_DIV)
  ) u_pattern (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (r_mode),
    .col_i       (r_col),
    .idx_i       (r_idx),
    .frame_end_i ((r_state == ST_DONE) && (r_mode == MODE_CHASE)),
    .pat_o       (w_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_pat  <= '0;
    end else begin
      r_we   <= (r_state == ST_STREAM);
      r_addr <= (r_state == ST_STREAM) ? {1'b0, r_idx} : 10'd0;
      r_pat  <= (r_state == ST_STREAM) ? w_pat : 16'd0;
    end
  end

`ifdef ALS_GAIN_EN
  logic [7:0]  r_als;
  logic [16:0] w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_als <= '0;
    else if (r_state == ST_IDLE && w_tick) r_als <= als_i;
  end

  assign w_sum   = {1'b0, zr_data_i, 8'h00} + 17'(r_als) * 17'(ALS_K);
  assign w_video = w_sum[16] ? FULL : w_sum[15:0];
`else
  assign w_video = {zr_data_i, 8'h00};
`endif

  // RAM data lands in the same cycle as its registered write strobe.
  assign wt_data_o = (r_we && r_mode == MODE_VIDEO) ? w_video : r_pat;
  assign wt_we_o   = r_we;
  assign wt_addr_o = r_addr;
  assign zr_addr_o = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_bl_refresh_sched.sv
// ============================================================================
//  Module : tb_bl_refresh_sched
//  Randomized scoreboard bench for bl_refresh_sched (ALS_GAIN_EN aware).
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bl_refresh_sched;

  localparam int ZC = 24, ZR = 15, NZ = ZC * ZR;
  localparam int CFG = 50, PER = 420, PL = 30, DIV = 2;
  localparam int NFRAMES = 14, RST_FRAME = 9;
`ifdef ALS_GAIN_EN
  localparam bit ALS_ON = 1'b1;
`else
  localparam bit ALS_ON = 1'b0;
`endif

  typedef struct packed {
    logic        last;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_s_n = 1'b0;
  logic [2:0]  mode;
  logic [7:0]  als;
  logic [7:0]  zr_data = 8'd0;
  logic [8:0]  zr_addr;
  logic        sdbp, we, busy, done;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic [8:0]  s_zr_addr;
  logic        s_sdbp, s_we, s_busy, s_done;
  logic [9:0]  s_waddr;
  logic [15:0] s_wdata;

  logic [7:0]  ram [NZ];
  exp_t        q[$];
  int          n_checks = 0, n_pass = 0, n_chase = 0, s_frames = 0, cyc = 0;
  int          plan [8] = '{1, 0, 3, 2, 2, 2, 2, 0};

  always #20 clk = ~clk;

  bl_refresh_sched #(
    .ZCOLS(ZC), .ZROWS(ZR), .CFG_CYCLES(CFG), .PERIOD(PER), .PULSE_LEN(PL), .CHASE_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .zr_addr_o(zr_addr), .zr_data_i(zr_data),
`ifdef ALS_GAIN_EN
    .als_i(als),
`endif
    .sdbp_o(sdbp), .wt_we_o(we), .wt_addr_o(waddr), .wt_data_o(wdata),
    .busy_o(busy), .frame_done_o(done)
  );

  // Four-zone instance exercises chase wrap-around within a short run.
  bl_refresh_sched #(
    .ZCOLS(2), .ZROWS(2), .CFG_CYCLES(10), .PERIOD(50), .PULSE_LEN(30), .CHASE_DIV(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_s_n), .mode_i(3'd2), .zr_addr_o(s_zr_addr), .zr_data_i(8'd0),
`ifdef ALS_GAIN_EN
    .als_i(8'd0),
`endif
    .sdbp_o(s_sdbp), .wt_we_o(s_we), .wt_addr_o(s_waddr), .wt_data_o(s_wdata),
    .busy_o(s_busy), .frame_done_o(s_done)
  );

  always @(posedge clk) zr_data <= ram[zr_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model(input int m, input int a, input int pos,
                                        input logic [7:0] g, input logic [7:0] al);
    int v;
    case (m)
      0: begin
        v = g * 256 + (ALS_ON ? al * 3 : 0);
        if (v > 65535) v = 65535;
      end
      1: v = 65535;
      2: v = (a == pos) ? 'h0FFF : 0;
      3: v = ((a % ZC) < ZC / 3) ? 65535 : ((a % ZC) < 2 * ZC / 3) ? 'h0100 : 0;
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic push_frame(input int m);
    exp_t e;
    int   pos;
    pos = (n_chase / DIV) % NZ;
    for (int a = 0; a < NZ; a++) begin
      e.last = 1'b0;
      e.addr = 10'(a);
      e.data = model(m, a, pos, ram[a], als);
      q.push_back(e);
    end
    e = '0;
    e.last = 1'b1;
    q.push_back(e);
    if (m == 2) n_chase++;
  endtask

  // Main monitor: strobe timing plus scoreboard pops.
  initial begin
    exp_t e;
    bit   prev_sdbp, first;
    int   rise_cyc, first_we, last_we;
    prev_sdbp = 0; first = 1; rise_cyc = 0; first_we = -1; last_we = -1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_sdbp = 0; first = 1; first_we = -1;
        continue;
      end
      if (sdbp && !prev_sdbp) begin
        if (first) check("first_sdbp_cycle", cyc, CFG + PER);
        else check("sdbp_period_phase", ((cyc - CFG - PER) % PER == 0), 1);
        check("busy_in_pulse", busy, 1);
        first = 0;
        rise_cyc = cyc;
      end
      if (!sdbp && prev_sdbp) check("sdbp_width", cyc - rise_cyc, PL);
      prev_sdbp = sdbp;
      if (we) begin
        if (q.size() == 0) check("write_unexpected", q.size(), 1);
        else begin
          e = q.pop_front();
          check("wt_not_done_slot", e.last, 0);
          check("wt_addr", waddr, e.addr);
          check("wt_data", wdata, e.data);
        end
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end else begin
        check("idle_addr_data", {waddr, wdata}, 0);
      end
      if (done) begin
        if (q.size() == 0) check("done_unexpected", q.size(), 1);
        else begin
          e = q.pop_front();
          check("done_after_all_writes", e.last, 1);
        end
        check("write_span", last_we - first_we, NZ - 1);
        check("done_after_last_write", cyc - last_we, 1);
        check("busy_at_done", busy, 0);
        first_we = -1;
      end
    end
  end

  // Small-instance monitor: one lit zone per frame, stepping 0,1,2,3,0,...
  initial begin
    int lit, lit_addr, writes;
    lit = 0; lit_addr = 0; writes = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_s_n) continue;
      if (s_we) begin
        writes++;
        if (s_wdata != 16'd0) begin
          lit++;
          lit_addr = int'(s_waddr);
          check("small_chase_value", s_wdata, 16'h0FFF);
        end
      end
      if (s_done) begin
        check("small_writes", writes, 4);
        check("small_lit_count", lit, 1);
        check("small_chase_pos", lit_addr, s_frames % 4);
        s_frames++;
        lit = 0; writes = 0;
      end
    end
  end

  // Stimulus: per-frame mode plan, mid-stream mode noise, one mid-stream reset.
  initial begin
    bit ok;
    for (int a = 0; a < NZ; a++) ram[a] = 8'(a);
    mode = 3'(plan[0]);
    als  = 8'($urandom);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    rst_s_n = 1'b1;
    for (int f = 0; f < NFRAMES; f++) begin
      ok = 0;
      for (int i = 0; i < 2 * PER && !ok; i++) begin
        @(posedge clk); #1;
        ok = sdbp;
      end
      check("sdbp_seen", ok, 1);
      if (!ok) break;
      push_frame(int'(mode));
      if (f == RST_FRAME) begin
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        n_chase = 0;
        #1;
        check("reset_ctrl_outputs", {sdbp, we, busy, done, zr_addr}, 0);
        check("reset_write_outputs", {waddr, wdata}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      repeat ($urandom_range(40, 300)) @(posedge clk);
      #1 mode = 3'($urandom_range(0, 7));
      ok = 0;
      for (int i = 0; i < 2 * PER && !ok; i++) begin
        @(posedge clk); #1;
        ok = done;
      end
      check("frame_done_seen", ok, 1);
      if (!ok) break;
      mode = (f + 1 < 8) ? 3'(plan[f + 1]) : 3'($urandom_range(0, 7));
      als  = 8'($urandom);
      if (f == 6)
        for (int a = 0; a < NZ; a++) ram[a] = 8'($urandom);
    end
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    check("small_frames_wrapped", (s_frames >= 8), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
